imem_loader: RTL
================

# imem_loader

Boot-time writer for the CPU32 instruction memory. Accepts a byte stream over a valid/ready handshake and packs it big-endian into 32-bit MIPS instruction words. Writes each word into instruction RAM at consecutive word-aligned byte addresses starting at 0, in the same addressing the fetch stage uses for `pc`. Holds the CPU in reset until the programmed word count has been stored.

## Interface
- `ADDR_W`, default 10: word-address width; capacity is 2^ADDR_W words.
- `clk`  in  1  sole clock; all logic on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `start`  in  1  single-cycle pulse that begins a load; sampled only in IDLE or DONE.
- `len`  in  ADDR_W+1  number of words to load; sampled on accepted `start`.
- `rx_data`  in  8  stream byte.
- `rx_valid`  in  1  `rx_data` is valid.
- `rx_ready`  out  1  loader accepts a byte this cycle.
- `mem_we`  out  1  instruction RAM write strobe; one cycle per word.
- `mem_addr`  out  32  byte address, always a multiple of 4 (`word_idx*4`).
- `mem_wdata`  out  32  assembled instruction word.
- `cpu_hold`  out  1  keeps the CPU in reset while high.
- `busy`  out  1  load in progress.
- `done`  out  1  load finished; stays high until the next `start` or reset.
- `err`  out  1  checksum mismatch (only with `IMEM_LOADER_CKSUM_EN`); otherwise tied to 0.

## Operation
- States:
  - IDLE: after reset.
  - RECV: collecting bytes 0..3 of the current word.
  - WRITE: strobe the word into RAM.
  - CKSUM: receive the checksum byte (feature build only).
  - DONE: load complete.
- Handshake: a byte transfers when `rx_valid && rx_ready`.
  - `rx_ready` = 1 only in RECV and CKSUM.
  - `rx_data` may change freely when not accepted; gaps in `rx_valid` are allowed and simply stall the loader.
- Byte order: the first byte of each group of four goes to `[31:24]`, the last to `[7:0]`. Bytes 20 08 FF FF therefore give 32'h2008FFFF.
- IDLE/DONE + `start`:
  - latch `len` and clear `word_idx`, `byte_idx` and `err`;
  - `done` <= 0, `cpu_hold` <= 1;
  - if `len` == 0, go to CKSUM (feature build) or DONE; otherwise go to RECV.
- RECV:
  - on each accepted byte, shift it into the word register and increment `byte_idx`;
  - on the 4th byte, go to WRITE.
- WRITE (one cycle):
  - `mem_we` = 1, `mem_addr` = `word_idx<<2`, `mem_wdata` = assembled word;
  - then increment `word_idx` and clear `byte_idx`;
  - if `word_idx+1 == len`, go to CKSUM or DONE; otherwise return to RECV.
- DONE: `done` = 1, `cpu_hold` = 0, `busy` = 0.
- `start` while `busy` is ignored.
- `len` larger than 2^ADDR_W is clamped to 2^ADDR_W; the address never wraps.
- Reset mid-load:
  - the next edge with `reset_n` = 0 returns to IDLE and discards any partial word;
  - words already written stay in RAM.

## Timing
- Reset values: `rx_ready` 0, `mem_we` 0, `mem_addr` 0, `mem_wdata` 0, `cpu_hold` 1, `busy` 0, `done` 0, `err` 0.
- `busy` is high from the cycle after an accepted `start` until the cycle DONE is entered.
- Last byte of a word accepted at cycle N → `mem_we` high at N+1 → `rx_ready` high again at N+2.
- Full-rate stream: 4 data cycles plus 1 write cycle per word, so a new word every 5 cycles.
- Last word written at cycle M → `done` = 1 and `cpu_hold` = 0 at M+1 (non-feature build).
- `mem_we` is never high for two consecutive cycles.

## Configuration
- `IMEM_LOADER_CKSUM_EN` defined:
  - after the last word, CKSUM accepts one byte;
  - that byte is compared against the XOR of all data bytes;
  - on mismatch `err` <= 1 and stays set until the next `start` or reset;
  - DONE is entered one cycle after the checksum byte is accepted, whether or not it matched.
- Not defined:
  - no CKSUM state; the loader goes straight from the last WRITE to DONE;
  - `err` is constant 0.

## Test plan
- Load 2 words: `len` = 2, bytes 20 08 FF FF AC 08 00 00 at full rate → writes (0, 32'h2008FFFF) and (4, 32'hAC080000); `done` = 1 and `cpu_hold` = 0 one cycle after the second write.
- Same stream with `rx_valid` low for 3 cycles between every byte → identical writes, with no extra or early `mem_we`.
- `len` = 0 → DONE one cycle after `start`, with no `mem_we` (non-feature build).
- `reset_n` low after 2 bytes of word 1 → IDLE, `cpu_hold` = 1, no write for word 1.
- A later `start` with `len` = 1 and bytes 3C 0F FF FF → write (0, 32'h3C0FFFFF).
- `start` pulsed mid-load → ignored; addresses continue 0, 4, 8.
- `IMEM_LOADER_CKSUM_EN` with the 2-word stream:
  - checksum byte 8C → `err` = 0;
  - checksum byte 8D → `err` = 1 and `done` = 1.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: boot-time loader that packs a byte stream big-endian into 32-bit words and writes them to instruction RAM.
// Optional trailing XOR checksum byte is enabled by defining IMEM_LOADER_CKSUM_EN.
module imem_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE      = {{ADDR_W{1'b0}}, 1'b1};

`ifdef IMEM_LOADER_CKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_RECV, S_WRITE, S_CKSUM, S_DONE} state_t;
  localparam state_t S_TAIL = S_CKSUM;
`else
  typedef enum logic [2:0] {S_IDLE, S_RECV, S_WRITE, S_DONE} state_t;
  localparam state_t S_TAIL = S_DONE;
`endif

  // Requests beyond RAM capacity are truncated so the address never wraps.
  function automatic logic [ADDR_W:0] clamp_len(input logic [ADDR_W:0] l);
    return (l > CAPACITY) ? CAPACITY : l;
  endfunction

  function automatic logic [31:0] shift_in(input logic [31:0] w, input logic [7:0] b);
    return {w[23:0], b};
  endfunction

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   word_idx;
  logic [ADDR_W:0]   word_nxt;
  logic [1:0]        byte_idx;
  logic [31:0]       word_q;
  logic              accept;
  logic              last_word;

  assign accept    = rx_valid && rx_ready;
  assign word_nxt  = word_idx + ONE;
  assign last_word = (word_nxt == len_q);

  always_comb begin
    rx_ready = (state_q == S_RECV);
`ifdef IMEM_LOADER_CKSUM_EN
    if (state_q == S_CKSUM) rx_ready = 1'b1;
`endif
  end

  assign mem_we    = (state_q == S_WRITE);
  assign mem_addr  = {{(30-ADDR_W){1'b0}}, word_idx[ADDR_W-1:0], 2'b00};
  assign mem_wdata = word_q;
  assign done      = (state_q == S_DONE);
  assign cpu_hold  = (state_q != S_DONE);
  assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) state_d = (len == '0) ? S_TAIL : S_RECV;
      end
      S_RECV: begin
        if (accept && byte_idx == 2'd3) state_d = S_WRITE;
      end
      S_WRITE: begin
        state_d = last_word ? S_TAIL : S_RECV;
      end
`ifdef IMEM_LOADER_CKSUM_EN
      S_CKSUM: begin
        if (accept) state_d = S_DONE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Word assembly and address bookkeeping; a reset discards any partial word.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      len_q    <= '0;
      word_idx <= '0;
      byte_idx <= '0;
      word_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            len_q    <= clamp_len(len);
            word_idx <= '0;
            byte_idx <= '0;
          end
        end
        S_RECV: begin
          if (accept) begin
            word_q   <= shift_in(word_q, rx_data);
            byte_idx <= byte_idx + 2'd1;
          end
        end
        S_WRITE: begin
          word_idx <= word_nxt;
          byte_idx <= '0;
        end
        default: ;
      endcase
    end
  end

`ifdef IMEM_LOADER_CKSUM_EN
  logic [7:0] cksum_q;
  logic       err_q;

  // Running XOR over data bytes, compared against the single trailing byte.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cksum_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            cksum_q <= '0;
            err_q   <= 1'b0;
          end
        end
        S_RECV: begin
          if (accept) cksum_q <= cksum_q ^ rx_data;
        end
        S_CKSUM: begin
          if (accept) err_q <= (rx_data != cksum_q);
        end
        default: ;
      endcase
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
